// File: rtl/rtc_bus_responder.sv
// Slave end of the RTC multiplexed address/data bus: synchronizes the strobes,
// latches an address, and serves byte writes/reads from a local register file.
module rtc_bus_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              ad_n,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              addr_valid,
    output logic              wr_pulse,
    output logic              rd_pulse,
    output logic              proto_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ADDR_WR = 2'd1;
    localparam logic [1:0] DATA_WR = 2'd2;
    localparam logic [1:0] DATA_RD = 2'd3;

    logic [1:0]        cs_sync;
    logic [1:0]        ad_sync;
    logic [1:0]        wr_sync;
    logic [1:0]        rd_sync;
    logic [DATA_W-1:0] data_meta;
    logic [DATA_W-1:0] data_s;
    logic              cs_s;
    logic              ad_s;
    logic              wr_s;
    logic              rd_s;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              err_hold;
    logic              err_hold_next;
    logic [DATA_W-1:0] shadow;
    logic [ADDR_W-1:0] addr_reg;

    logic              addr_commit;
    logic              bus_we;
    logic              err_now;
    logic              rd_start;
    logic              rd_stop;
    logic              rd_done;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: every register in an always_ff uses <= so all flops see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= 2'b11;
            ad_sync   <= 2'b11;
            wr_sync   <= 2'b11;
            rd_sync   <= 2'b11;
            data_meta <= '0;
            data_s    <= '0;
        end else begin
            cs_sync   <= {cs_sync[0], cs_n};
            ad_sync   <= {ad_sync[0], ad_n};
            wr_sync   <= {wr_sync[0], wr_n};
            rd_sync   <= {rd_sync[0], rd_n};
            data_meta <= bus_in;
            data_s    <= data_meta;
        end
    end

    assign cs_s = cs_sync[1];
    assign ad_s = ad_sync[1];
    assign wr_s = wr_sync[1];
    assign rd_s = rd_sync[1];

    // err_hold keeps a violation to a single proto_err pulse until the strobes release.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_next    = state;
        err_hold_next = err_hold;
        addr_commit   = 1'b0;
        bus_we        = 1'b0;
        err_now       = 1'b0;
        rd_start      = 1'b0;
        rd_stop       = 1'b0;
        rd_done       = 1'b0;

        case (state)
            IDLE: begin
                if (cs_s) begin
                    err_hold_next = 1'b0;
                end else if (err_hold) begin
                    if (wr_s && rd_s) begin
                        err_hold_next = 1'b0;
                    end
                end else if (!wr_s && !rd_s) begin
                    err_now       = 1'b1;
                    err_hold_next = 1'b1;
                end else if (!rd_s && !ad_s) begin
                    err_now       = 1'b1;
                    err_hold_next = 1'b1;
                end else if (!wr_s) begin
                    state_next = ad_s ? DATA_WR : ADDR_WR;
                end else if (!rd_s) begin
                    state_next = DATA_RD;
                    rd_start   = 1'b1;
                end
            end

            ADDR_WR: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (wr_s) begin
                    addr_commit = 1'b1;
                    state_next  = IDLE;
                end
            end

            DATA_WR: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (wr_s) begin
                    if (addr_valid) begin
                        bus_we = 1'b1;
                    end else begin
                        err_now = 1'b1;
                    end
                    state_next = IDLE;
                end
            end

            DATA_RD: begin
                if (cs_s) begin
                    rd_stop    = 1'b1;
                    state_next = IDLE;
                end else if (rd_s) begin
                    rd_stop    = 1'b1;
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            err_hold   <= 1'b0;
            shadow     <= '0;
            addr_reg   <= '0;
            addr_valid <= 1'b0;
            wr_pulse   <= 1'b0;
            rd_pulse   <= 1'b0;
            proto_err  <= 1'b0;
            bus_out    <= '0;
            bus_oe     <= 1'b0;
        end else begin
            state     <= state_next;
            err_hold  <= err_hold_next;
            wr_pulse  <= bus_we;
            rd_pulse  <= rd_done;
            proto_err <= err_now;

            if (state == ADDR_WR || state == DATA_WR) begin
                shadow <= data_s;
            end

            if (addr_commit) begin
                addr_reg   <= shadow[ADDR_W-1:0];
                addr_valid <= 1'b1;
            end

            // Read data is captured once on entry and held for the whole phase.
            if (rd_start) begin
                bus_out <= addr_valid ? mem[addr_reg] : '1;
                bus_oe  <= 1'b1;
            end else if (rd_stop) begin
                bus_oe <= 1'b0;
            end
        end
    end

    // NOTE: the register file is cleared by reset, so it is built from flops, not RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            loc_rdata <= '0;
        end else begin
            if (loc_we) begin
                mem[loc_addr] <= loc_wdata;
            end
            // The later assignment wins, giving the bus priority on an address collision.
            if (bus_we) begin
                mem[addr_reg] <= shadow;
            end
            loc_rdata <= mem[loc_addr];
        end
    end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Bus-responder model of the RTC's multiplexed address/data interface. It answers the chip-select / address-data / write / read strobe sequence produced by the RTC read-write controller. It latches an address on an address-phase write, stores or returns a byte from an internal register file on data-phase writes and reads, and drives the bus during reads. It is the slave end used for closed-loop simulation and FPGA self-test of the controller. A local port lets timekeeping logic update registers.

## Interface
- ADDR_W, 4, register-file address width; DEPTH = 2**ADDR_W bytes
- DATA_W, 8, bus and register width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs_n  in  1  chip select, active low
- ad_n  in  1  0 = address phase, 1 = data phase
- wr_n  in  1  write strobe, active low
- rd_n  in  1  read strobe, active low
- bus_in  in  DATA_W  value on the bus driven by the controller
- bus_out  out  DATA_W  read data driven to the bus
- bus_oe  out  1  bus_out enable; high only in a read phase
- loc_we  in  1  local write enable
- loc_addr  in  ADDR_W  local read/write address
- loc_wdata  in  DATA_W  local write data
- loc_rdata  out  DATA_W  registered read of mem[loc_addr]
- addr_valid  out  1  an address has been latched since reset
- wr_pulse  out  1  one-cycle pulse on each committed bus data write
- rd_pulse  out  1  one-cycle pulse on each completed bus read
- proto_err  out  1  one-cycle pulse on a protocol violation

## Operation
- cs_n, ad_n, wr_n and rd_n each pass through a 2-FF synchronizer, producing cs_s, ad_s, wr_s and rd_s. These reset to 1.
- bus_in passes through a matching 2-stage delay, producing data_s. This keeps it aligned with the strobes.
- Register file: DEPTH × DATA_W, reset to all zeros. addr_reg resets to 0. Address bits above ADDR_W are ignored.
- FSM states are IDLE, ADDR_WR, DATA_WR and DATA_RD. The reset state is IDLE.
- **IDLE**
  - cs_s=0, wr_s=0, rd_s=1, ad_s=0 → ADDR_WR.
  - cs_s=0, wr_s=0, rd_s=1, ad_s=1 → DATA_WR.
  - cs_s=0, rd_s=0, wr_s=1, ad_s=1 → DATA_RD.
  - cs_s=0 with wr_s=0 and rd_s=0 → proto_err pulse; stay in IDLE.
  - cs_s=0, rd_s=0, ad_s=0 → proto_err pulse; stay in IDLE.
- **ADDR_WR**
  - Each cycle, shadow <= data_s.
  - When wr_s returns to 1 with cs_s=0: addr_reg <= shadow[ADDR_W-1:0], addr_valid <= 1, → IDLE.
  - If cs_s=1 before wr_s rises: abort with no update, → IDLE.
- **DATA_WR**
  - Each cycle, shadow <= data_s.
  - When wr_s rises with cs_s=0 and addr_valid=1: mem[addr_reg] <= shadow, wr_pulse, → IDLE.
  - When wr_s rises with addr_valid=0: discard the data, proto_err pulse, → IDLE.
  - If cs_s rises first: abort, → IDLE.
- **DATA_RD**
  - On entry: bus_out <= mem[addr_reg], or all-ones if addr_valid=0; bus_oe <= 1.
  - bus_out holds for the whole phase, even if the register changes.
  - rd_s rising with cs_s=0 → bus_oe <= 0, rd_pulse, → IDLE.
  - cs_s rising → bus_oe <= 0 with no rd_pulse, → IDLE.
- ad_s changing mid-phase is ignored; the phase type is fixed at entry.
- The address persists across any number of data phases. There is no auto-increment.
- **Local port**
  - loc_we=1 writes mem[loc_addr] <= loc_wdata.
  - If a bus write commits to the same address in the same cycle, the bus write wins.
  - loc_rdata <= mem[loc_addr] every cycle. A same-cycle write returns the old value.
- Reset mid-phase returns to IDLE with every output at its reset value and the memory cleared.

## Timing
- Reset values: bus_out=0, bus_oe=0, loc_rdata=0, addr_valid=0, wr_pulse=0, rd_pulse=0, proto_err=0.
- Input sampled at edge k → synchronized value visible after edge k+1 → FSM acts at edge k+2.
- Read, rd_n falling: rd_n sampled low at edge k → bus_oe=1 and bus_out valid from edge k+2.
- Read, rd_n rising: rd_n sampled high at edge k → bus_oe=0 and rd_pulse=1 from edge k+2, for one cycle.
- Write commit: wr_n sampled high at edge k → mem, addr_reg and wr_pulse updated at edge k+2.
- The committed value is bus_in as sampled at edge k-1. bus_in must be stable for ≥3 cycles before wr_n rises.
- The minimum low width of any strobe is 4 clk. The minimum gap between phases is 3 clk.
- Outputs are undefined while these are violated, but the FSM must always return to IDLE.
- wr_pulse, rd_pulse and proto_err each last exactly 1 cycle.

## Test plan
- Address write then read:
  - Stimulus: after reset, loc_we writes 0x5A to address 3. Then an address phase (ad_n=0) with bus_in=0x03, wr_n low for 40 cycles. Then a read phase with rd_n low for 40 cycles.
  - Required: addr_valid=1; bus_oe=1 two cycles after rd_n falls; bus_out=0x5A; rd_pulse once; bus_oe=0 two cycles after rd_n rises.
- Bus write:
  - Stimulus: address 0x07, then a data-phase write of 0xC3.
  - Required: wr_pulse once; loc_addr=7 gives loc_rdata=0xC3 one cycle later. A following read returns 0xC3.
- Read before any address phase:
  - Required: bus_out=0xFF, bus_oe asserted, no proto_err.
- Data write before any address phase:
  - Required: proto_err pulse, no wr_pulse, memory unchanged.
- Protocol violations:
  - wr_n and rd_n both low with cs_n low → proto_err, bus_oe stays 0.
  - cs_n rising mid-read → bus_oe drops with no rd_pulse.
- Same-address collision and reset:
  - Stimulus: a bus write of 0x11 and loc_we of 0x22 to address 5 commit in the same cycle.
  - Required: mem[5]=0x11.
  - Stimulus: reset asserted during DATA_RD.
  - Required: bus_oe=0 immediately and loc_rdata of any address reads 0.
